// File: rtl/dct_feed_pkg.sv
// dct_feed_pkg: shared FSM state type and sizing helpers for the DCT block feeder.
package dct_feed_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      GAP   = 2'd2
   } feed_state_e;

   // Samples held by one bank for a given block edge
   function automatic int blk_sz(input int n);
      return n * n;
   endfunction

   // Counter width able to hold 0..g, never narrower than one bit
   function automatic int gap_w(input int g);
      return (g < 1) ? 1 : $clog2(g + 1);
   endfunction

   // Sizes for the default 8x8 block with a 93-cycle gap
   localparam int BLK_SZ = blk_sz(8);
   localparam int IDX_W  = $clog2(BLK_SZ);
   localparam int GAP_W  = gap_w(93);

endpackage

// File: rtl/dct_blk_buf.sv
// dct_blk_buf: two-bank simple dual-port sample store, one write port and
// one read port with a registered read (maps onto block RAM).
module dct_blk_buf #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 128,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_data_q;

   // Write port and registered read port; contents are never reset
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data_q <= mem[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/dct_block_feeder.sv
// dct_block_feeder: buffers a raster pixel stream into a ping-pong pair of
// BLK_N x BLK_N banks, replays each full block to the DCT core as one burst
// followed by an idle gap, and tags the returning coefficient stream.
// Optional input stall counter enabled by defining DCT_FEED_STATS_EN.
module dct_block_feeder
   import dct_feed_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int COEF_W     = 12,
   parameter int BLK_N      = 8,
   parameter int GAP_CYCLES = 93,
   parameter int BLK_CNT_W  = 16
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [DATA_W-1:0]        pix_in,
   input  logic                     pix_valid,
   output logic                     pix_ready,
   output logic [DATA_W-1:0]        xin,
   output logic                     xin_valid,
   input  logic [COEF_W-1:0]        dct_in,
   input  logic                     rdy_in,
   output logic [COEF_W-1:0]        coef_out,
   output logic                     coef_valid,
   output logic [$clog2(BLK_N)-1:0] coef_row,
   output logic [$clog2(BLK_N)-1:0] coef_col,
   output logic                     coef_last,
   output logic [BLK_CNT_W-1:0]     blk_cnt,
   output logic [15:0]              stall_cnt
);

   localparam int SZ = blk_sz(BLK_N);
   localparam int IW = $clog2(SZ);
   localparam int LW = $clog2(BLK_N);
   localparam int GW = gap_w(GAP_CYCLES);
   localparam logic [IW-1:0] IDX_LAST = IW'(SZ - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

   // write side
   logic [IW-1:0] wr_idx_q, wr_idx_d;
   logic          wr_bank_q, wr_bank_d;
   logic [1:0]    full_q, full_d;
   logic          accept;

   // issue side
   feed_state_e   state_q, state_d;
   logic [IW-1:0] rd_idx_q, rd_idx_d;
   logic          rd_bank_q, rd_bank_d;
   logic [GW-1:0] gap_q, gap_d;
   logic          xin_valid_q, xin_valid_d;
   logic          rd_en;
   logic          rd_done;
   logic [DATA_W-1:0] rd_data;

   // output framing
   logic [IW-1:0]        coef_idx_q, coef_idx_d;
   logic [COEF_W-1:0]    coef_out_q, coef_out_d;
   logic                 coef_valid_q, coef_valid_d;
   logic [LW-1:0]        coef_row_q, coef_row_d;
   logic [LW-1:0]        coef_col_q, coef_col_d;
   logic                 coef_last_q, coef_last_d;
   logic [BLK_CNT_W-1:0] blk_cnt_q, blk_cnt_d;

   assign pix_ready = ~full_q[wr_bank_q];
   assign accept    = pix_valid & pix_ready;

   dct_blk_buf #(
      .DATA_W (DATA_W),
      .DEPTH  (2 * SZ)
   ) u_buf (
      .clk     (CLK),
      .wr_en   (accept),
      .wr_addr ({wr_bank_q, wr_idx_q}),
      .wr_data (pix_in),
      .rd_en   (rd_en),
      .rd_addr ({rd_bank_q, rd_idx_q}),
      .rd_data (rd_data)
   );

   // Fill index, write bank and bank-full flags; a bank freed by the reader
   // and the other bank filled by the writer in one cycle both take effect
   always_comb begin
      wr_idx_d  = wr_idx_q;
      wr_bank_d = wr_bank_q;
      full_d    = full_q;
      if (rd_done) begin
         full_d[rd_bank_q] = 1'b0;
      end
      if (accept) begin
         if (wr_idx_q == IDX_LAST) begin
            wr_idx_d          = '0;
            wr_bank_d         = ~wr_bank_q;
            full_d[wr_bank_q] = 1'b1;
         end else begin
            wr_idx_d = wr_idx_q + 1'b1;
         end
      end
   end

   // Write-side registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_idx_q  <= '0;
         wr_bank_q <= 1'b0;
         full_q    <= '0;
      end else begin
         wr_idx_q  <= wr_idx_d;
         wr_bank_q <= wr_bank_d;
         full_q    <= full_d;
      end
   end

   // Issue FSM next state: wait for a full bank, stream it without bubbles,
   // then hold off for the programmed gap
   always_comb begin
      state_d     = state_q;
      rd_idx_d    = rd_idx_q;
      rd_bank_d   = rd_bank_q;
      gap_d       = gap_q;
      xin_valid_d = 1'b0;
      rd_en       = 1'b0;
      rd_done     = 1'b0;
      case (state_q)
         IDLE: begin
            if (full_q[rd_bank_q]) begin
               state_d  = BURST;
               rd_idx_d = '0;
            end
         end
         BURST: begin
            rd_en       = 1'b1;
            xin_valid_d = 1'b1;
            rd_idx_d    = rd_idx_q + 1'b1;
            if (rd_idx_q == IDX_LAST) begin
               rd_done   = 1'b1;
               rd_idx_d  = '0;
               rd_bank_d = ~rd_bank_q;
               gap_d     = '0;
               state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
            end
         end
         GAP: begin
            gap_d = gap_q + 1'b1;
            if (gap_q == GAP_LAST) begin
               gap_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Issue FSM state and registered burst-valid flag
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         rd_idx_q    <= '0;
         rd_bank_q   <= 1'b0;
         gap_q       <= '0;
         xin_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_idx_q    <= rd_idx_d;
         rd_bank_q   <= rd_bank_d;
         gap_q       <= gap_d;
         xin_valid_q <= xin_valid_d;
      end
   end

   // The RAM read register is the xin register; force zero outside bursts
   assign xin       = xin_valid_q ? rd_data : '0;
   assign xin_valid = xin_valid_q;

   // Coefficient framing: row/col from a raster index that advances only
   // while the core presents data
   always_comb begin
      coef_idx_d   = coef_idx_q;
      coef_out_d   = coef_out_q;
      coef_valid_d = rdy_in;
      coef_row_d   = coef_row_q;
      coef_col_d   = coef_col_q;
      coef_last_d  = 1'b0;
      blk_cnt_d    = blk_cnt_q;
      if (rdy_in) begin
         coef_out_d = dct_in;
         coef_row_d = coef_idx_q[IW-1:LW];
         coef_col_d = coef_idx_q[LW-1:0];
         coef_idx_d = coef_idx_q + 1'b1;
         if (coef_idx_q == IDX_LAST) begin
            coef_last_d = 1'b1;
            blk_cnt_d   = blk_cnt_q + 1'b1;
         end
      end
   end

   // Coefficient framing registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         coef_idx_q   <= '0;
         coef_out_q   <= '0;
         coef_valid_q <= 1'b0;
         coef_row_q   <= '0;
         coef_col_q   <= '0;
         coef_last_q  <= 1'b0;
         blk_cnt_q    <= '0;
      end else begin
         coef_idx_q   <= coef_idx_d;
         coef_out_q   <= coef_out_d;
         coef_valid_q <= coef_valid_d;
         coef_row_q   <= coef_row_d;
         coef_col_q   <= coef_col_d;
         coef_last_q  <= coef_last_d;
         blk_cnt_q    <= blk_cnt_d;
      end
   end

   assign coef_out   = coef_out_q;
   assign coef_valid = coef_valid_q;
   assign coef_row   = coef_row_q;
   assign coef_col   = coef_col_q;
   assign coef_last  = coef_last_q;
   assign blk_cnt    = blk_cnt_q;

`ifdef DCT_FEED_STATS_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;

   // Saturating count of cycles where the source is held off
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (pix_valid && !pix_ready && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   // Stall counter register, cleared only by reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`else
   assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_dct_block_feeder.sv
// tb_dct_block_feeder: scoreboard bench for dct_block_feeder (default parameters).
module tb_dct_block_feeder;

   localparam int DATA_W     = 8;
   localparam int COEF_W     = 12;
   localparam int BLK_N      = 8;
   localparam int GAP_CYCLES = 93;
   localparam int BLK_CNT_W  = 16;
   localparam int SZ         = BLK_N * BLK_N;
   localparam int LW         = 3;

   logic                 CLK = 1'b0;
   logic                 RST = 1'b1;
   logic [DATA_W-1:0]    pix_in = '0;
   logic                 pix_valid = 1'b0;
   logic                 pix_ready;
   logic [DATA_W-1:0]    xin;
   logic                 xin_valid;
   logic [COEF_W-1:0]    dct_in = '0;
   logic                 rdy_in = 1'b0;
   logic [COEF_W-1:0]    coef_out;
   logic                 coef_valid;
   logic [LW-1:0]        coef_row;
   logic [LW-1:0]        coef_col;
   logic                 coef_last;
   logic [BLK_CNT_W-1:0] blk_cnt;
   logic [15:0]          stall_cnt;

   dct_block_feeder #(
      .DATA_W     (DATA_W),
      .COEF_W     (COEF_W),
      .BLK_N      (BLK_N),
      .GAP_CYCLES (GAP_CYCLES),
      .BLK_CNT_W  (BLK_CNT_W)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .pix_in     (pix_in),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .xin        (xin),
      .xin_valid  (xin_valid),
      .dct_in     (dct_in),
      .rdy_in     (rdy_in),
      .coef_out   (coef_out),
      .coef_valid (coef_valid),
      .coef_row   (coef_row),
      .coef_col   (coef_col),
      .coef_last  (coef_last),
      .blk_cnt    (blk_cnt),
      .stall_cnt  (stall_cnt)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [COEF_W-1:0]    val;
      logic [LW-1:0]        row;
      logic [LW-1:0]        col;
      logic                 last;
      logic [BLK_CNT_W-1:0] blk;
   } coef_exp_t;

   logic [DATA_W-1:0] xin_sb[$];
   coef_exp_t         coef_sb[$];

   int n_cmp = 0;
   int n_bad = 0;

   // bench observations
   int cyc = 0;
   int run = 0;
   int low_run = 0;
   int seen_burst = 0;
   int first_valid_cyc = 0;
   int last_acc_cyc = 0;
   int stall_seen = 0;
   int n_xin = 0;
   int n_bursts = 0;
   logic rdy_prev = 1'b0;

   // coefficient model
   int exp_idx = 0;
   int exp_blk = 0;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(posedge CLK);
         cyc++;
      end
   end

   // Monitor: sample away from the active edge, pop scoreboards, push accepts
   initial begin
      logic [DATA_W-1:0] ex;
      coef_exp_t         ce;
      forever begin
         @(negedge CLK);
         if (RST) begin
            run        = 0;
            low_run    = 0;
            seen_burst = 0;
            rdy_prev   = rdy_in;
         end else begin
            if (xin_valid) begin
               if (run == 0) begin
                  first_valid_cyc = cyc;
                  if (seen_burst != 0) begin
                     chk_eq("gap_min", 32'(low_run >= GAP_CYCLES), 32'd1);
                  end
                  low_run = 0;
               end
               run++;
               n_xin++;
               chk_eq("xin_expected", 32'(xin_sb.size() != 0), 32'd1);
               if (xin_sb.size() != 0) begin
                  ex = xin_sb.pop_front();
                  chk_eq("xin", 32'(xin), 32'(ex));
               end
            end else begin
               chk_eq("xin_idle_zero", 32'(xin), 32'd0);
               if (run > 0) begin
                  chk_eq("burst_len", 32'(run), 32'(SZ));
                  n_bursts++;
                  $display("tb: burst %0d complete, %0d samples, ends cycle %0d", n_bursts, run, cyc);
                  seen_burst = 1;
                  run = 0;
               end
               low_run++;
            end

            if (pix_valid && pix_ready) begin
               xin_sb.push_back(pix_in);
               last_acc_cyc = cyc + 1;
            end
            if (pix_valid && !pix_ready) begin
               stall_seen++;
            end

            chk_eq("coef_valid", 32'(coef_valid), 32'(rdy_prev));
            if (coef_valid) begin
               chk_eq("coef_expected", 32'(coef_sb.size() != 0), 32'd1);
               if (coef_sb.size() != 0) begin
                  ce = coef_sb.pop_front();
                  chk_eq("coef_out", 32'(coef_out), 32'(ce.val));
                  chk_eq("coef_row", 32'(coef_row), 32'(ce.row));
                  chk_eq("coef_col", 32'(coef_col), 32'(ce.col));
                  chk_eq("coef_last", 32'(coef_last), 32'(ce.last));
                  chk_eq("blk_cnt", 32'(blk_cnt), 32'(ce.blk));
                  if (ce.last) begin
                     $display("tb: coefficient block done, blk_cnt=%0d", blk_cnt);
                  end
               end
            end else begin
               chk_eq("coef_last_idle", 32'(coef_last), 32'd0);
            end
            rdy_prev = rdy_in;
         end
      end
   end

   // Present one pixel and hold it until accepted (bounded)
   task automatic send_pix(input logic [DATA_W-1:0] v);
      int w;
      w = 0;
      pix_valid = 1'b1;
      pix_in    = v;
      do begin
         @(negedge CLK);
         w++;
      end while (!pix_ready && w < 2000);
      if (!pix_ready) begin
         chk_eq("pix_ready_timeout", 32'(pix_ready), 32'd1);
      end
      @(posedge CLK);
      #1;
      pix_valid = 1'b0;
   endtask

   // Present one coefficient with rdy_in high; queue its expected framing
   task automatic drive_coef(input logic [COEF_W-1:0] v);
      coef_exp_t e;
      rdy_in = 1'b1;
      dct_in = v;
      e.val  = v;
      e.row  = LW'(exp_idx / BLK_N);
      e.col  = LW'(exp_idx % BLK_N);
      e.last = (exp_idx == SZ - 1);
      if (e.last) exp_blk++;
      e.blk  = BLK_CNT_W'(exp_blk);
      exp_idx = (exp_idx + 1) % SZ;
      coef_sb.push_back(e);
      @(posedge CLK);
      #1;
   endtask

   task automatic coef_idle(input int n);
      rdy_in = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
      end
   endtask

   // Wait until every accepted pixel has come back out and the burst ended
   task automatic wait_drain(input string tag);
      int w;
      w = 0;
      while ((xin_sb.size() != 0 || xin_valid) && w < 4000) begin
         @(negedge CLK);
         w++;
      end
      chk_eq(tag, 32'(xin_sb.size()), 32'd0);
      @(negedge CLK);
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
      end
      #1;
   endtask

   task automatic chk_stats(input string tag);
`ifdef DCT_FEED_STATS_EN
      chk_eq(tag, 32'(stall_cnt), 32'(stall_seen));
`else
      chk_eq(tag, 32'(stall_cnt), 32'd0);
`endif
   endtask

   initial begin
      int st0;
      int n0;
      int acc;
      int w;
      logic acc_now;

      // ---------------- reset state
      wait_cycles(4);
      RST = 1'b0;
      @(negedge CLK);
      chk_eq("rst_pix_ready", 32'(pix_ready), 32'd1);
      chk_eq("rst_xin_valid", 32'(xin_valid), 32'd0);
      chk_eq("rst_xin", 32'(xin), 32'd0);
      chk_eq("rst_coef_valid", 32'(coef_valid), 32'd0);
      chk_eq("rst_coef_last", 32'(coef_last), 32'd0);
      chk_eq("rst_coef_out", 32'(coef_out), 32'd0);
      chk_eq("rst_blk_cnt", 32'(blk_cnt), 32'd0);
      chk_eq("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      @(posedge CLK);
      #1;

      // ---------------- single block of 0x01
      st0 = stall_seen;
      for (int i = 0; i < SZ; i++) send_pix(8'h01);
      wait_drain("t1_drain");
      chk_eq("t1_no_stall", 32'(stall_seen - st0), 32'd0);
      chk_eq("t1_latency", 32'(first_valid_cyc - last_acc_cyc), 32'd2);
      wait_cycles(GAP_CYCLES + 10);
      @(negedge CLK);
      chk_eq("t1_gap_quiet", 32'(low_run >= GAP_CYCLES), 32'd1);
      chk_eq("t1_gap_xin_valid", 32'(xin_valid), 32'd0);
      @(posedge CLK);
      #1;

      // ---------------- three back-to-back blocks 0x00..0x3F
      st0 = stall_seen;
      n0  = n_xin;
      for (int b = 0; b < 3; b++) begin
         for (int i = 0; i < SZ; i++) send_pix(DATA_W'(i));
      end
      wait_drain("t2_drain");
      chk_eq("t2_samples", 32'(n_xin - n0), 32'(3 * SZ));
      chk_eq("t2_stall_cycles", 32'(stall_seen - st0), 32'd1);
      chk_stats("t2_stall_cnt");
      wait_cycles(GAP_CYCLES + 10);

      // ---------------- coefficient framing, uninterrupted block
      for (int v = 0; v < SZ; v++) drive_coef(COEF_W'(v));
      rdy_in = 1'b0;
      @(negedge CLK);
      chk_eq("f1_blk_cnt", 32'(blk_cnt), 32'd1);
      @(posedge CLK);
      #1;

      // ---------------- framing with a 5-cycle pause after coefficient 20
      for (int v = 0; v < SZ; v++) begin
         drive_coef(COEF_W'((v * 37 + 5) & 12'hFFF));
         if (v == 20) coef_idle(5);
      end
      rdy_in = 1'b0;
      @(negedge CLK);
      chk_eq("f2_blk_cnt", 32'(blk_cnt), 32'd2);
      chk_eq("f2_sb_empty", 32'(coef_sb.size()), 32'd0);
      @(posedge CLK);
      #1;

      // ---------------- pix_valid held high for 300 cycles
      st0 = stall_seen;
      acc = 0;
      for (int c = 0; c < 300; c++) begin
         pix_valid = 1'b1;
         pix_in    = DATA_W'(acc * 3 + 7);
         @(negedge CLK);
         acc_now = pix_ready;
         @(posedge CLK);
         #1;
         if (acc_now) acc++;
      end
      pix_valid = 1'b0;
      chk_eq("t3_stalled", 32'(stall_seen - st0 > 0), 32'd1);
      chk_stats("t3_stall_cnt");
      while (acc % SZ != 0) begin
         send_pix(DATA_W'(acc * 3 + 7));
         acc++;
      end
      wait_drain("t3_drain");
      chk_stats("t3_stall_cnt_end");
      wait_cycles(GAP_CYCLES + 10);

      // ---------------- reset during burst sample 30
      for (int i = 0; i < SZ; i++) send_pix(DATA_W'(8'h40 + i));
      for (int i = 0; i < 10; i++) send_pix(DATA_W'(8'hC0 + i));
      w = 0;
      do begin
         @(negedge CLK);
         w++;
      end while (!(xin_valid && xin == DATA_W'(8'h40 + 30)) && w < 500);
      chk_eq("r_reached_s30", 32'(w < 500), 32'd1);
      @(posedge CLK);
      #1;
      RST = 1'b1;
      @(posedge CLK);
      #1;
      RST = 1'b0;
      xin_sb.delete();
      coef_sb.delete();
      exp_idx    = 0;
      exp_blk    = 0;
      stall_seen = 0;
      @(negedge CLK);
      chk_eq("r_xin_valid", 32'(xin_valid), 32'd0);
      chk_eq("r_pix_ready", 32'(pix_ready), 32'd1);
      chk_eq("r_blk_cnt", 32'(blk_cnt), 32'd0);
      chk_eq("r_stall_cnt", 32'(stall_cnt), 32'd0);
      @(posedge CLK);
      #1;
      wait_cycles(20);
      n0 = n_xin;
      for (int i = 0; i < SZ; i++) send_pix(DATA_W'(8'h90 + i));
      wait_drain("r_drain");
      chk_eq("r_samples", 32'(n_xin - n0), 32'(SZ));
      chk_stats("r_stall_cnt_end");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, got t=%0t required earlier end", $time);
      $fatal(1);
   end

endmodule
